// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR sequencer: width defaults,
// FSM state encoding and the coefficient value loaded at reset.
package fir_pkg;

  localparam int DEF_N1   = 8;   // coefficient width (signed)
  localparam int DEF_N2   = 16;  // sample width (signed)
  localparam int DEF_N3   = 32;  // accumulator / result width (signed)
  localparam int DEF_TAPS = 8;   // number of taps, power of two

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_t;

  // Every coefficient comes out of reset as +16
  localparam logic signed [7:0] DEF_COEF = 8'sh10;

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file: TAPS entries of N1 bits, loaded with DEF_COEF on
// reset, one gated write port and one combinational read port.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter  int N1   = DEF_N1,
  parameter  int TAPS = DEF_TAPS,
  localparam int AW   = $clog2(TAPS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_waddr,
  input  logic signed [N1-1:0] i_wdata,
  input  logic [AW-1:0]        i_raddr,
  output logic signed [N1-1:0] o_rdata
);

  logic signed [N1-1:0] r_coef [TAPS];

  // Reset loads the default value everywhere; a write updates one entry
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < TAPS; i++) begin
        r_coef[i] <= N1'(DEF_COEF);
      end
    end else if (i_we) begin
      for (int i = 0; i < TAPS; i++) begin
        if (i_waddr == AW'(i)) begin
          r_coef[i] <= i_wdata;
        end
      end
    end
  end

  assign o_rdata = r_coef[i_raddr];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Serial FIR engine: accepts one sample per handshake, shifts it into a TAPS
// deep history and walks one shared signed multiplier over all taps, one tap
// per cycle. The product is registered before accumulation, so the MAC state
// lasts TAPS+1 cycles (TAPS products plus one drain cycle) and the result is
// presented TAPS+1 edges after acceptance.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter  int N1   = DEF_N1,
  parameter  int N2   = DEF_N2,
  parameter  int N3   = DEF_N3,
  parameter  int TAPS = DEF_TAPS,
  localparam int AW   = $clog2(TAPS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [N1-1:0] coef_wdata,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [N2-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [N3-1:0] out_data,
  output logic                 busy
);

  localparam int PW = N1 + N2;

  fir_state_t           r_state;
  logic signed [N2-1:0] r_hist [TAPS];
  logic signed [N3-1:0] r_acc;
  logic signed [N3-1:0] r_prod;
  logic signed [N3-1:0] r_out_data;
  logic                 r_out_valid;
  // One bit wider than a tap index so the drain cycle (idx == TAPS) is visible
  logic [AW:0]          r_idx;

  logic                 w_idle;
  logic                 w_accept;
  logic                 w_coef_we;
  logic [AW-1:0]        w_tap;
  logic signed [N1-1:0] w_coef;
  logic signed [N2-1:0] w_hist_sel;
  logic signed [PW-1:0] w_mul;
  logic signed [N3-1:0] w_prod_ext;
  logic                 w_last;

  assign w_idle    = (r_state == IDLE);
  assign w_accept  = w_idle && in_valid;
  // Coefficients are only writable between transactions
  assign w_coef_we = w_idle && coef_we;
  assign w_tap     = r_idx[AW-1:0];
  assign w_last    = (r_idx == (AW+1)'(TAPS));

  fir_coef_bank #(
    .N1   (N1),
    .TAPS (TAPS)
  ) u_coef_bank (
    .CLK     (CLK),
    .RST     (RST),
    .i_we    (w_coef_we),
    .i_waddr (coef_addr),
    .i_wdata (coef_wdata),
    .i_raddr (w_tap),
    .o_rdata (w_coef)
  );

  // Full-precision signed product, then sign-extended (or wrapped) to N3
  assign w_hist_sel = r_hist[w_tap];
  assign w_mul      = PW'(w_coef) * PW'(w_hist_sel);
  assign w_prod_ext = N3'(w_mul);

  // History shift register: newest sample lands in tap 0 on acceptance only
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < TAPS; i++) begin
        r_hist[i] <= '0;
      end
    end else if (w_accept) begin
      r_hist[0] <= in_data;
      for (int i = 1; i < TAPS; i++) begin
        r_hist[i] <= r_hist[i-1];
      end
    end
  end

  // Sequencer FSM with product pipeline register and wrapping accumulator
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_prod      <= '0;
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc   <= '0;
            r_prod  <= '0;
            r_idx   <= '0;
            r_state <= MAC;
          end
        end
        MAC: begin
          r_prod <= w_prod_ext;
          r_acc  <= r_acc + r_prod;
          r_idx  <= r_idx + (AW+1)'(1);
          if (w_last) begin
            r_out_data  <= r_acc + r_prod;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = w_idle;
  assign busy      = (r_state == MAC) || (r_state == DONE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: impulse, step, programmed taps,
// backpressure, wrap at two accumulator widths and reset mid-MAC.
module tb_fir_mac_sequencer;

  logic               CLK;
  logic               RST;
  logic               coef_we;
  logic [2:0]         coef_addr;
  logic signed [7:0]  coef_wdata;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               out_ready;

  logic               in_ready,  in_ready24;
  logic               out_valid, out_valid24;
  logic signed [31:0] out_data;
  logic signed [23:0] out_data24;
  logic               busy, busy24;

  int checks;
  int failures;
  int cyc;
  int prev_acc;
  int last_gap;

  fir_mac_sequencer u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  fir_mac_sequencer #(.N3(24)) u_dut24 (
    .CLK        (CLK),
    .RST        (RST),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .in_valid   (in_valid),
    .in_ready   (in_ready24),
    .in_data    (in_data),
    .out_valid  (out_valid24),
    .out_ready  (out_ready),
    .out_data   (out_data24),
    .busy       (busy24)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic write_coef(input logic [2:0] a, input logic signed [7:0] d);
    @(negedge CLK);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    @(posedge CLK); #1;
    coef_we = 1'b0;
  endtask

  // One transaction: optional coefficient write alongside acceptance, optional
  // write attempt during MAC (must be ignored), then latency and result check.
  task automatic run_txn(input logic signed [15:0] x, input longint exp, input string tag,
                         input bit acc_wr, input logic [2:0] wa, input logic signed [7:0] wd,
                         input bit mac_wr);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) check_val({tag, "_rdy_timeout"}, in_ready, 1);
    in_data  = x;
    in_valid = 1'b1;
    if (acc_wr) begin
      coef_we = 1'b1; coef_addr = wa; coef_wdata = wd;
    end
    @(posedge CLK); #1;
    last_gap = cyc - prev_acc;
    prev_acc = cyc;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    in_data  = 16'sh1234;
    n = 0;
    if (mac_wr) begin
      coef_we = 1'b1; coef_addr = 3'd3; coef_wdata = 8'sd99;
      @(posedge CLK); #1;
      coef_we = 1'b0;
      n = 1;
    end
    while (!out_valid && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    check_val({tag, "_lat"}, n, 9);
    check_val({tag, "_dat"}, out_data, exp);
    $display("txn %s in=%0d out=%0d lat=%0d", tag, x, out_data, n);
  endtask

  initial begin
    checks = 0; failures = 0; prev_acc = 0; last_gap = 0;
    RST = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // Reset state
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_busy24", busy24, 0);

    // 1: impulse with default coefficients (16)
    run_txn(16'sd100, 1600, "imp0", 0, 3'd0, 8'sd0, 0);
    for (int k = 1; k < 8; k++) run_txn(16'sd0, 1600, "imp", 0, 3'd0, 8'sd0, 0);
    run_txn(16'sd0, 0, "imp_end", 0, 3'd0, 8'sd0, 0);

    // 2: step of 1000, ramp then steady state; acceptances 11 edges apart
    for (int k = 1; k <= 10; k++) begin
      run_txn(16'sd1000, 16000 * ((k > 8) ? 8 : k), "step", 0, 3'd0, 8'sd0, 0);
      if (k > 1) check_val("step_gap", last_gap, 11);
    end

    // 3: programmed taps; c0 written together with acceptance, a MAC-time
    // write to c3 must have no effect
    do_reset();
    write_coef(3'd1, -8'sd1);
    write_coef(3'd2, 8'sd2);
    write_coef(3'd3, -8'sd2);
    write_coef(3'd4, 8'sd0);
    write_coef(3'd5, 8'sd0);
    write_coef(3'd6, 8'sd0);
    write_coef(3'd7, 8'sd127);
    run_txn(-16'sd5, -5, "prog0", 1, 3'd0, 8'sd1, 1);
    run_txn(16'sd0, 5, "prog1", 0, 3'd0, 8'sd0, 0);
    run_txn(16'sd0, -10, "prog2", 0, 3'd0, 8'sd0, 0);
    run_txn(16'sd0, 10, "prog3", 0, 3'd0, 8'sd0, 0);
    run_txn(16'sd0, 0, "prog4", 0, 3'd0, 8'sd0, 0);
    run_txn(16'sd0, 0, "prog5", 0, 3'd0, 8'sd0, 0);
    run_txn(16'sd0, 0, "prog6", 0, 3'd0, 8'sd0, 0);
    run_txn(16'sd0, -635, "prog7", 0, 3'd0, 8'sd0, 0);

    // 4: output backpressure
    do_reset();
    out_ready = 1'b0;
    run_txn(16'sd10, 160, "bp", 0, 3'd0, 8'sd0, 0);
    in_valid = 1'b1;
    in_data  = 16'sd1000;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check_val("bp_valid", out_valid, 1);
      check_val("bp_data", out_data, 160);
      check_val("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    check_val("bp_valid_drop", out_valid, 0);
    check_val("bp_in_ready_back", in_ready, 1);
    check_val("bp_not_busy", busy, 0);
    check_val("bp_data_hold", out_data, 160);
    in_valid = 1'b0;
    run_txn(16'sd0, 160, "bp_after", 0, 3'd0, 8'sd0, 0);

    // 5: extremes, 32-bit exact and 24-bit wrap
    do_reset();
    for (int k = 0; k < 8; k++) write_coef(3'(k), -8'sd128);
    for (int k = 1; k <= 8; k++) begin
      run_txn(-16'sd32768, 64'sd4194304 * k, "ext", 0, 3'd0, 8'sd0, 0);
      if (k == 2) check_val("ext24_k2", out_data24, -8388608);
    end
    check_val("ext24_valid", out_valid24, 1);
    check_val("ext24_wrap", out_data24, 0);

    // 6: reset during MAC, then impulse with defaults again
    @(negedge CLK);
    while (!in_ready) @(negedge CLK);
    in_data = 16'sd100; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check_val("mrst_valid", out_valid, 0);
    check_val("mrst_data", out_data, 0);
    check_val("mrst_busy", busy, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_val("mrst_in_ready", in_ready, 1);
    run_txn(16'sd100, 1600, "mrst_imp", 0, 3'd0, 8'sd0, 0);
    run_txn(16'sd0, 1600, "mrst_imp1", 0, 3'd0, 8'sd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
